multiplier_4_bit_unsigned: RTL and testbench
============================================

// Module: multiplier_4_bit_unsigned
// PURPOSE
//  - Multiplies two 4-bit magnitudes carried in 5-bit two's-complement operands and produces a 9-bit signed product.
//  - Registered, fully pipelined datapath element: accepts one new operand pair every clock, no handshake.
//  - Leaf arithmetic block for the combinational-circuits datapath; feeds downstream accumulate/display logic.
// PARAMETERS
//  - none; widths are fixed at 5-bit operands and a 9-bit product.
// PORTS
//  - Clocking: one clock; reset is asynchronous and active-low.
//  - i_clk    input   1  rising-edge clock
//  - i_rst_n  input   1  asynchronous active-low reset
//  - i_au     input   5  operand A, signed two's complement, valid range -15..+15
//  - i_bu     input   5  operand B, signed two's complement, valid range -15..+15
//  - o_fu     output  9  product A*B, signed two's complement, range -225..+225
// BEHAVIOUR
//  - Reset: i_rst_n low forces every pipeline register and o_fu to 0 immediately, with no clock edge required.
//  - Reset release: the first capture happens on the first rising i_clk edge after i_rst_n goes high.
//  - Asserting i_rst_n mid-stream discards all in-flight products. No stale value appears after release.
//  - Sign/magnitude split:
//    - sign = i_au[4] ^ i_bu[4]
//    - mag_x = |x|, 4 bits
//  - Operand -16 (5'b10000) has no 4-bit magnitude. It saturates to magnitude 15, so it is treated as -15.
//  - Core: 4x4 unsigned shift-and-add array, mag_a*mag_b, giving an 8-bit magnitude with a maximum of 225.
//  - Result: o_fu = sign ? -{1'b0,mag_p} : {1'b0,mag_p}, sign-extended to 9 bits.
//    - A zero product is always 9'd0, never a negative zero.
//    - Overflow is impossible by construction.
//  - Latency: o_fu is registered.
//    - Default latency is 1 clock: operands present at edge N give the product on o_fu after edge N.
//    - Throughput is one product per clock.
//  - o_fu holds its value while the inputs are stable. X/Z on the inputs is not filtered.
// CONFIGURATION
//  - Macro MULTIPLIER_4_BIT_UNSIGNED_IN_REG_EN.
//  - Defined:
//    - Adds an input register stage on i_au/i_bu, also reset to 0.
//    - Latency becomes 2 clocks. Throughput is unchanged at one product per clock.
//  - Undefined:
//    - The operands feed the combinational core directly.
//    - Only the output register remains; latency is 1 clock.
// TESTING
//  - Run every test with the macro both defined and undefined. Check o_fu at the configured latency.
//  - T1 reset: hold i_rst_n=0 with i_au=5, i_bu=3 -> o_fu=0 asynchronously. Release -> o_fu=15 after the latency.
//  - T2 zero: i_au=0, i_bu=0 -> o_fu=0.
//  - T3 extremes: i_au=-15, i_bu=15 -> o_fu=-225 (9'h11F); i_au=-15, i_bu=-15 -> o_fu=225.
//  - T4 zero sign: i_au=-15, i_bu=0 -> o_fu=0, not negative.
//  - T5 small/saturate: i_au=1, i_bu=3 -> o_fu=3; i_au=-16, i_bu=-16 -> o_fu=225; i_au=-16, i_bu=2 -> o_fu=-30.
//  - T6 back-to-back plus exhaustive sweep:
//    - Apply a new pair every clock. Each product appears exactly the latency later, in order.
//    - Pulse i_rst_n low mid-stream -> o_fu=0 at once, and no pre-reset products follow release.
//    - Finish with all 1024 operand pairs against a reference model.

Source files
------------

// File: rtl/multiplier_4_bit_unsigned.sv
// Signed 5-bit x 5-bit magnitude multiplier: sign/magnitude split, 4x4 shift-and-add core, registered 9-bit product.
// Define MULTIPLIER_4_BIT_UNSIGNED_IN_REG_EN to add an operand register stage (latency 2 instead of 1).
module multiplier_4_bit_unsigned (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_au,
   input  logic [4:0] i_bu,
   output logic [8:0] o_fu
);

   logic [4:0] a_op;
   logic [4:0] b_op;
   logic       sign;
   logic [3:0] mag_a;
   logic [3:0] mag_b;
   logic [7:0] mag_p;
   logic [8:0] prod_c;

   // Absolute value in 4 bits; -16 has no 4-bit magnitude and saturates to 15.
   function automatic logic [3:0] mag_of(input logic [4:0] x);
      if (!x[4])
         return x[3:0];
      else if (x[3:0] == 4'd0)
         return 4'd15;
      else
         return ~x[3:0] + 4'd1;
   endfunction

`ifdef MULTIPLIER_4_BIT_UNSIGNED_IN_REG_EN
   // NOTE: the reset clears only these few flops and the output register; every stage
   // is reset so no stale product can surface after release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_op <= '0;
         b_op <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the pre-edge value.
         a_op <= i_au;
         b_op <= i_bu;
      end
   end
`else
   assign a_op = i_au;
   assign b_op = i_bu;
`endif

   assign sign  = a_op[4] ^ b_op[4];
   assign mag_a = mag_of(a_op);
   assign mag_b = mag_of(b_op);

   always_comb begin
      // NOTE: default first so the loop cannot leave mag_p unassigned (no latch).
      mag_p = '0;
      for (int i = 0; i < 4; i++) begin
         if (mag_b[i])
            mag_p = mag_p + ({4'd0, mag_a} << i);
      end
   end

   // A zero magnitude never takes the negate path, so there is no negative zero.
   always_comb begin
      prod_c = {1'b0, mag_p};
      if (sign && (mag_p != 8'd0))
         prod_c = ~{1'b0, mag_p} + 9'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_fu <= '0;
      else
         o_fu <= prod_c;
   end

endmodule

// File: tb/tb_multiplier_4_bit_unsigned.sv
// Self-checking bench for multiplier_4_bit_unsigned: directed table, reset sequences, exhaustive sweep, random stream.
// Latency follows MULTIPLIER_4_BIT_UNSIGNED_IN_REG_EN, matching the RTL build.
module tb_multiplier_4_bit_unsigned;

`ifdef MULTIPLIER_4_BIT_UNSIGNED_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [4:0] i_au = '0;
   logic [4:0] i_bu = '0;
   logic [8:0] o_fu;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic [8:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[7];

   multiplier_4_bit_unsigned dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_au   (i_au),
      .i_bu   (i_bu),
      .o_fu   (o_fu)
   );

   always #5 i_clk = ~i_clk;

   // Reference: plain integer arithmetic, -16 treated as -15.
   function automatic logic [8:0] model(input logic [4:0] a, input logic [4:0] b);
      int va;
      int vb;
      int p;
      va = $signed(a);
      vb = $signed(b);
      if (va == -16) va = -15;
      if (vb == -16) vb = -15;
      p = va * vb;
      return p[8:0];
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (%b) expected %0d (%b)", name, $signed(got), got, $signed(exp), exp);
      end
   endtask

   // One clock with a new operand pair; output compared with the product from LAT-1 edges earlier.
   task automatic step(input logic [4:0] a, input logic [4:0] b, input string name);
      i_au = a;
      i_bu = b;
      @(posedge i_clk);
      exp_q.push_back(model(a, b));
      #1;
      if (exp_q.size() >= LAT) check(name, o_fu, exp_q.pop_front());
   endtask

   task automatic assert_reset();
      i_rst_n = 1'b0;
      exp_q.delete();
   endtask

   // Reset flops hold zero, so the first LAT-1 outputs after release are zero.
   task automatic release_reset();
      i_rst_n = 1'b1;
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back(9'd0);
   endtask

   initial begin
      vecs[0] = '{a: 5'd0,     b: 5'd0,     exp: 9'd0,      name: "T2_zero"};
      vecs[1] = '{a: -5'sd15,  b: 5'd15,    exp: 9'h11F,    name: "T3_neg_ext"};
      vecs[2] = '{a: -5'sd15,  b: -5'sd15,  exp: 9'd225,    name: "T3_pos_ext"};
      vecs[3] = '{a: -5'sd15,  b: 5'd0,     exp: 9'd0,      name: "T4_zero_sign"};
      vecs[4] = '{a: 5'd1,     b: 5'd3,     exp: 9'd3,      name: "T5_small"};
      vecs[5] = '{a: 5'b10000, b: 5'b10000, exp: 9'd225,    name: "T5_sat_both"};
      vecs[6] = '{a: 5'b10000, b: 5'd2,     exp: -9'sd30,   name: "T5_sat_one"};

      // T1: asynchronous reset, then release with 5*3 held.
      i_au = 5'd5;
      i_bu = 5'd3;
      #1;
      check("T1_reset_at_start", o_fu, 9'd0);
      @(posedge i_clk);
      #1;
      check("T1_reset_held", o_fu, 9'd0);
      release_reset();
      for (int i = 0; i < LAT; i++) step(5'd5, 5'd3, "T1_release_stream");
      check("T1_release_15", o_fu, 9'd15);

      // Async assertion mid-cycle while the output is nonzero.
      #2;
      assert_reset();
      #1;
      check("T1_async_clear", o_fu, 9'd0);
      @(posedge i_clk);
      #1;
      release_reset();

      // Directed table: hold each pair for the full latency, then compare with the table value.
      foreach (vecs[k]) begin
         for (int i = 0; i < LAT; i++) step(vecs[k].a, vecs[k].b, {vecs[k].name, "_stream"});
         check(vecs[k].name, o_fu, vecs[k].exp);
      end

      // T6: back-to-back pairs with a mid-stream reset pulse.
      step(5'd7, 5'd9, "T6_b2b");
      step(-5'sd4, 5'd6, "T6_b2b");
      step(5'd15, 5'd15, "T6_b2b");
      #2;
      assert_reset();
      #1;
      check("T6_pulse_clear", o_fu, 9'd0);
      #2;
      release_reset();
      for (int i = 0; i < 4; i++) step(5'(i + 2), -5'sd3, "T6_after_pulse");

      // T6: exhaustive sweep of all 1024 operand pairs, one per clock.
      for (int a = 0; a < 32; a++)
         for (int b = 0; b < 32; b++)
            step(5'(a), 5'(b), "T6_sweep");

      // Random stream with occasional reset pulses.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            #2;
            assert_reset();
            #1;
            check("rand_reset_clear", o_fu, 9'd0);
            #2;
            release_reset();
         end
         step(5'($urandom), 5'($urandom), "rand_stream");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
